// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT H-bridge pulse-driver sequencer.
package swipt_pkg;

    localparam int unsigned FREQ_W = 20;
    localparam int unsigned DIV_W  = 4;

    localparam logic [DIV_W-1:0] DIV_MIN   = 4'd2;
    localparam logic [DIV_W-1:0] DIV_START = 4'd15;
    localparam logic [DIV_W-1:0] DATA_DIV0 = 4'd8;

    typedef enum logic [1:0] {
        StOff,
        StArm,
        StRamp,
        StRun
    } state_e;

    function automatic logic [DIV_W-1:0] div_max(input logic [DIV_W-1:0] a,
                                                 input logic [DIV_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Divisor the driver starts from when it is (re)armed.
    function automatic logic [DIV_W-1:0] arm_div(input logic             ramp,
                                                 input logic [DIV_W-1:0] tgt);
        return ramp ? div_max(DIV_START, tgt) : tgt;
    endfunction

endpackage

// File: rtl/swipt_ramp.sv
// Soft-start stepper: counts period ticks and requests one divisor decrement per dwell.
module swipt_ramp
    import swipt_pkg::*;
#(
    parameter int unsigned RAMP_DWELL = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic [DIV_W-1:0] cur_div_i,
    input  logic [DIV_W-1:0] tgt_div_i,
    output logic             step_o,
    output logic [DIV_W-1:0] next_div_o
);

    localparam int unsigned CNT_W = $clog2(RAMP_DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             dwell_done;

    assign dwell_done = tick_i && (cnt_q == CNT_LAST);

    // Gated on cur > tgt so the divisor can never step past the target or wrap.
    assign step_o     = en_i && dwell_done && (cur_div_i > tgt_div_i);
    assign next_div_o = cur_div_i - 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q <= '0;
        end else if (tick_i) begin
            if (dwell_done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/swipt_sched.sv
// Config/sequencing controller for the SWIPT H-bridge driver: reset hold, soft-start ramp,
// period-aligned divisor updates and per-period data-bit divisor modulation.
module swipt_sched
    import swipt_pkg::*;
#(
    parameter int unsigned RAMP_DWELL = 16,
    parameter int unsigned HOLD_CYC   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [FREQ_W-1:0] cfg_freq_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cfg_ramp_i,
    output logic              cfg_err_o,
    input  logic              period_tick_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic              data_bit_i,
    output logic              drv_nrst_o,
    output logic [FREQ_W-1:0] drv_freq_o,
    output logic [DIV_W-1:0]  drv_div_o,
    output logic              busy_o
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    state_e            state_q;
    logic              drv_nrst_q;
    logic [FREQ_W-1:0] drv_freq_q;
    logic [DIV_W-1:0]  drv_div_q;
    logic [FREQ_W-1:0] tgt_freq_q;
    logic [DIV_W-1:0]  tgt_div_q;
    logic              ramp_q;
    logic              pend_q;
    logic              cfg_err_q;
    logic              busy_q;
    logic [HOLD_W-1:0] hold_cnt_q;

    logic              cfg_acc;
    logic              cfg_ok;
    logic [DIV_W-1:0]  cfg_div_c;
    logic [FREQ_W-1:0] ld_freq;
    logic [DIV_W-1:0]  ld_div;
    logic              ld_ramp;
    logic [DIV_W-1:0]  data_div;
    logic              ramp_step;
    logic [DIV_W-1:0]  ramp_next;

    assign cfg_ready_o = !rst_i && ((state_q == StOff) || (state_q == StRun && !pend_q));
    assign cfg_acc     = cfg_valid_i && cfg_ready_o;
    assign cfg_ok      = cfg_acc && (cfg_freq_i != '0);
    assign cfg_div_c   = (cfg_div_i < DIV_MIN) ? DIV_MIN : cfg_div_i;

    // Targets as they will be after this cycle, so OFF can arm on the accepting cycle.
    assign ld_freq = cfg_ok ? cfg_freq_i : tgt_freq_q;
    assign ld_div  = cfg_ok ? cfg_div_c  : tgt_div_q;
    assign ld_ramp = cfg_ok ? cfg_ramp_i : ramp_q;

    assign data_ready_o = !rst_i && (state_q == StRun) && period_tick_i && !pend_q;
    assign data_div     = (data_valid_i && !data_bit_i) ? div_max(DATA_DIV0, tgt_div_q)
                                                        : tgt_div_q;

    swipt_ramp #(
        .RAMP_DWELL(RAMP_DWELL)
    ) u_ramp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (state_q == StRamp),
        .tick_i     (period_tick_i),
        .cur_div_i  (drv_div_q),
        .tgt_div_i  (tgt_div_q),
        .step_o     (ramp_step),
        .next_div_o (ramp_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StOff;
            drv_nrst_q <= 1'b0;
            drv_freq_q <= '0;
            drv_div_q  <= DIV_START;
            tgt_freq_q <= '0;
            tgt_div_q  <= DIV_MIN;
            ramp_q     <= 1'b0;
            pend_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            cfg_err_q <= cfg_acc && (cfg_freq_i == '0);
            if (cfg_ok) begin
                tgt_freq_q <= cfg_freq_i;
                tgt_div_q  <= cfg_div_c;
                ramp_q     <= cfg_ramp_i;
            end

            if (!enable_i) begin
                state_q    <= StOff;
                drv_nrst_q <= 1'b0;
                pend_q     <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StOff: begin
                        if (ld_freq != '0) begin
                            state_q    <= StArm;
                            drv_nrst_q <= 1'b0;
                            drv_freq_q <= ld_freq;
                            drv_div_q  <= arm_div(ld_ramp, ld_div);
                            hold_cnt_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end

                    StArm: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            drv_nrst_q <= 1'b1;
                            if (ramp_q && (drv_div_q > tgt_div_q)) begin
                                state_q <= StRamp;
                            end else begin
                                state_q <= StRun;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end

                    StRamp: begin
                        if (drv_div_q <= tgt_div_q) begin
                            state_q <= StRun;
                            busy_q  <= 1'b0;
                        end else if (ramp_step) begin
                            drv_div_q <= ramp_next;
                            if (ramp_next == tgt_div_q) begin
                                state_q <= StRun;
                                busy_q  <= 1'b0;
                            end
                        end
                    end

                    StRun: begin
                        if (cfg_ok && (cfg_freq_i != tgt_freq_q)) begin
                            // New frequency: reset the driver mid-period and re-arm.
                            state_q    <= StArm;
                            drv_nrst_q <= 1'b0;
                            drv_freq_q <= ld_freq;
                            drv_div_q  <= arm_div(ld_ramp, ld_div);
                            hold_cnt_q <= '0;
                            busy_q     <= 1'b1;
                        end else begin
                            if (cfg_ok && (cfg_div_c != tgt_div_q)) begin
                                pend_q <= 1'b1;
                            end
                            if (period_tick_i) begin
                                if (pend_q) begin
                                    pend_q <= 1'b0;
                                    if (ramp_q && (tgt_div_q < drv_div_q)) begin
                                        state_q <= StRamp;
                                        busy_q  <= 1'b1;
                                    end else begin
                                        drv_div_q <= tgt_div_q;
                                    end
                                end else begin
                                    drv_div_q <= data_div;
                                end
                            end
                        end
                    end

                    default: begin
                        state_q <= StOff;
                    end
                endcase
            end
        end
    end

    assign cfg_err_o  = cfg_err_q;
    assign drv_nrst_o = drv_nrst_q;
    assign drv_freq_o = drv_freq_q;
    assign drv_div_o  = drv_div_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_swipt_sched.sv
// Directed self-checking bench for swipt_sched.
module tb_swipt_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [19:0] cfg_freq;
    logic [3:0]  cfg_div;
    logic        cfg_ramp;
    logic        cfg_err;
    logic        period_tick;
    logic        data_valid;
    logic        data_ready;
    logic        data_bit;
    logic        drv_nrst;
    logic [19:0] drv_freq;
    logic [3:0]  drv_div;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    swipt_sched #(
        .RAMP_DWELL(16),
        .HOLD_CYC  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_freq_i   (cfg_freq),
        .cfg_div_i    (cfg_div),
        .cfg_ramp_i   (cfg_ramp),
        .cfg_err_o    (cfg_err),
        .period_tick_i(period_tick),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .data_bit_i   (data_bit),
        .drv_nrst_o   (drv_nrst),
        .drv_freq_o   (drv_freq),
        .drv_div_o    (drv_div),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cycle();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
    endtask

    task automatic send_cfg(input logic [19:0] f, input logic [3:0] d, input logic r);
        cfg_valid = 1'b1;
        cfg_freq  = f;
        cfg_div   = d;
        cfg_ramp  = r;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_nrst(output int low);
        low = 0;
        for (int i = 0; i < 20 && drv_nrst !== 1'b1; i++) begin
            low++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++; if (drv_nrst !== 1'b0) $display("FAIL rst_nrst: got %0b want 0", drv_nrst); else pass_cnt++;
        total_cnt++; if (drv_freq !== 20'd0) $display("FAIL rst_freq: got %0d want 0", drv_freq); else pass_cnt++;
        total_cnt++; if (drv_div !== 4'd15) $display("FAIL rst_div: got %0d want 15", drv_div); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (cfg_err !== 1'b0) $display("FAIL rst_err: got %0b want 0", cfg_err); else pass_cnt++;
        total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready: got %0b want 0", cfg_ready); else pass_cnt++;
        total_cnt++; if (data_ready !== 1'b0) $display("FAIL rst_data_ready: got %0b want 0", data_ready); else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL off_cfg_ready: got %0b want 1", cfg_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL off_no_arm: got busy %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_cold_start();
        int low;
        enable = 1'b1;
        send_cfg(20'd50000, 4'd4, 1'b0);
        total_cnt++; if (busy !== 1'b1) $display("FAIL cold_arm_busy: got %0b want 1", busy); else pass_cnt++;
        total_cnt++; if (drv_freq !== 20'd50000) $display("FAIL cold_freq: got %0d want 50000", drv_freq); else pass_cnt++;
        wait_nrst(low);
        total_cnt++; if (low !== 4) $display("FAIL cold_hold_len: got %0d want 4", low); else pass_cnt++;
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL cold_div: got %0d want 4", drv_div); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cold_run_busy: got %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_soft_start();
        int low;
        int bad;
        int rdy;
        enable = 1'b0;
        step();
        enable = 1'b1;
        send_cfg(20'd50000, 4'd4, 1'b1);
        total_cnt++; if (drv_div !== 4'd15) $display("FAIL ss_arm_div: got %0d want 15", drv_div); else pass_cnt++;
        wait_nrst(low);
        total_cnt++; if (low !== 4) $display("FAIL ss_hold_len: got %0d want 4", low); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ss_ramp_busy: got %0b want 1", busy); else pass_cnt++;
        bad = 0;
        rdy = 0;
        for (int t = 1; t <= 176; t++) begin
            if (cfg_ready !== 1'b0) rdy++;
            tick_cycle();
            if (drv_div !== 4'(15 - t / 16)) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL ss_steps: got %0d bad steps want 0", bad); else pass_cnt++;
        total_cnt++; if (rdy !== 0) $display("FAIL ss_cfg_ready: got %0d ready cycles want 0", rdy); else pass_cnt++;
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL ss_final_div: got %0d want 4", drv_div); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ss_run_busy: got %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_div_update();
        int drops;
        drops = 0;
        send_cfg(20'd50000, 4'd6, 1'b0);
        if (drv_nrst !== 1'b1) drops++;
        total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL du_pend_ready: got %0b want 0", cfg_ready); else pass_cnt++;
        step();
        if (drv_nrst !== 1'b1) drops++;
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL du_hold_div: got %0d want 4", drv_div); else pass_cnt++;
        tick_cycle();
        if (drv_nrst !== 1'b1) drops++;
        total_cnt++; if (drv_div !== 4'd6) $display("FAIL du_new_div: got %0d want 6", drv_div); else pass_cnt++;
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL du_ready_back: got %0b want 1", cfg_ready); else pass_cnt++;
        // Config accept coinciding with a tick: update waits for the following tick.
        cfg_valid   = 1'b1;
        cfg_freq    = 20'd50000;
        cfg_div     = 4'd5;
        cfg_ramp    = 1'b0;
        period_tick = 1'b1;
        step();
        cfg_valid   = 1'b0;
        period_tick = 1'b0;
        total_cnt++; if (drv_div !== 4'd6) $display("FAIL du_coincide_div: got %0d want 6", drv_div); else pass_cnt++;
        tick_cycle();
        total_cnt++; if (drv_div !== 4'd5) $display("FAIL du_coincide_next: got %0d want 5", drv_div); else pass_cnt++;
        send_cfg(20'd50000, 4'd0, 1'b0);
        tick_cycle();
        total_cnt++; if (drv_div !== 4'd2) $display("FAIL du_clamp: got %0d want 2", drv_div); else pass_cnt++;
        send_cfg(20'd50000, 4'd4, 1'b1);
        tick_cycle();
        if (drv_nrst !== 1'b1) drops++;
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL du_raise_no_ramp: got %0d want 4", drv_div); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL du_raise_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (drops !== 0) $display("FAIL du_nrst_drop: got %0d drops want 0", drops); else pass_cnt++;
    endtask

    task automatic test_data_mod();
        int bits[5]    = '{1, 0, 0, 1, 0};
        int exp_div[5] = '{4, 8, 8, 4, 8};
        int hits;
        int idle;
        hits = 0;
        idle = 0;
        for (int k = 0; k < 5; k++) begin
            data_valid = 1'b1;
            data_bit   = bits[k][0];
            step();
            if (data_ready !== 1'b0) idle++;
            period_tick = 1'b1;
            #1;
            if (data_ready === 1'b1) hits++;
            step();
            period_tick = 1'b0;
            total_cnt++;
            if (drv_div !== 4'(exp_div[k]))
                $display("FAIL dm_div_%0d: got %0d want %0d", k, drv_div, exp_div[k]);
            else
                pass_cnt++;
        end
        data_valid = 1'b0;
        tick_cycle();
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL dm_return: got %0d want 4", drv_div); else pass_cnt++;
        total_cnt++; if (hits !== 5) $display("FAIL dm_ready_ticks: got %0d want 5", hits); else pass_cnt++;
        total_cnt++; if (idle !== 0) $display("FAIL dm_ready_idle: got %0d want 0", idle); else pass_cnt++;
    endtask

    task automatic test_freq_change();
        int low;
        send_cfg(20'd40000, 4'd4, 1'b0);
        total_cnt++; if (drv_nrst !== 1'b0) $display("FAIL fc_nrst_drop: got %0b want 0", drv_nrst); else pass_cnt++;
        total_cnt++; if (drv_freq !== 20'd40000) $display("FAIL fc_freq: got %0d want 40000", drv_freq); else pass_cnt++;
        wait_nrst(low);
        total_cnt++; if (low !== 4) $display("FAIL fc_hold_len: got %0d want 4", low); else pass_cnt++;
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL fc_div: got %0d want 4", drv_div); else pass_cnt++;
    endtask

    task automatic test_cfg_err();
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL ce_ready: got %0b want 1", cfg_ready); else pass_cnt++;
        send_cfg(20'd0, 4'd9, 1'b0);
        total_cnt++; if (cfg_err !== 1'b1) $display("FAIL ce_pulse: got %0b want 1", cfg_err); else pass_cnt++;
        total_cnt++; if (drv_nrst !== 1'b1) $display("FAIL ce_nrst: got %0b want 1", drv_nrst); else pass_cnt++;
        step();
        total_cnt++; if (cfg_err !== 1'b0) $display("FAIL ce_once: got %0b want 0", cfg_err); else pass_cnt++;
        tick_cycle();
        total_cnt++; if (drv_div !== 4'd4) $display("FAIL ce_div_kept: got %0d want 4", drv_div); else pass_cnt++;
        total_cnt++; if (drv_freq !== 20'd40000) $display("FAIL ce_freq_kept: got %0d want 40000", drv_freq); else pass_cnt++;
    endtask

    task automatic test_abort();
        int low;
        enable = 1'b0;
        step();
        enable = 1'b1;
        send_cfg(20'd40000, 4'd4, 1'b1);
        wait_nrst(low);
        for (int t = 0; t < 20; t++) tick_cycle();
        total_cnt++; if (drv_div !== 4'd14) $display("FAIL ab_ramp_div: got %0d want 14", drv_div); else pass_cnt++;
        enable = 1'b0;
        step();
        total_cnt++; if (drv_nrst !== 1'b0) $display("FAIL ab_nrst: got %0b want 0", drv_nrst); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ab_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL ab_off_ready: got %0b want 1", cfg_ready); else pass_cnt++;
        enable = 1'b1;
        step();
        total_cnt++; if (busy !== 1'b1) $display("FAIL ab_rearm: got %0b want 1", busy); else pass_cnt++;
        total_cnt++; if (drv_freq !== 20'd40000) $display("FAIL ab_rearm_freq: got %0d want 40000", drv_freq); else pass_cnt++;
        total_cnt++; if (drv_div !== 4'd15) $display("FAIL ab_rearm_div: got %0d want 15", drv_div); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (drv_freq !== 20'd0) $display("FAIL mr_freq: got %0d want 0", drv_freq); else pass_cnt++;
        total_cnt++; if (drv_div !== 4'd15) $display("FAIL mr_div: got %0d want 15", drv_div); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mr_busy: got %0b want 0", busy); else pass_cnt++;
        step();
        total_cnt++; if (busy !== 1'b0) $display("FAIL mr_targets_cleared: got busy %0b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        cfg_valid   = 1'b0;
        cfg_freq    = '0;
        cfg_div     = '0;
        cfg_ramp    = 1'b0;
        period_tick = 1'b0;
        data_valid  = 1'b0;
        data_bit    = 1'b0;
        test_reset();
        test_cold_start();
        test_soft_start();
        test_div_update();
        test_data_mod();
        test_freq_change();
        test_cfg_err();
        test_abort();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/swipt_sched.md
Name: swipt_sched

Overview:
- Configuration and sequencing controller for the SWIPT H-bridge pulse driver.
- Accepts target frequency and pulse divisor from the host or power-optimisation logic via valid/ready, and sequences the driver through reset and a soft-start duty ramp.
- Applies divisor changes only at period boundaries.
- Modulates the per-period pulse divisor from a serial data-bit stream for in-band data transfer.

Parameters:
- FREQ_W, 20, width of frequency word (driver freq input).
- DIV_W, 4, width of pulse divisor (pulse = period/div).
- DIV_MIN, 2, smallest legal divisor (50 % pulse); lower requests clamp to this.
- DIV_START, 15, soft-start initial divisor.
- RAMP_DWELL, 16, periods spent at each ramp step.
- HOLD_CYC, 4, cycles the driver is held in reset when a new frequency is loaded.
- DATA_DIV0, 8, divisor used for a period carrying data bit 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  level; 0 forces the driver off.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_freq  in  FREQ_W  target frequency.
- cfg_div  in  DIV_W  target pulse divisor.
- cfg_ramp  in  1  1 = soft-start when a new frequency is loaded.
- cfg_err  out  1  one-cycle pulse: request with cfg_freq==0 was consumed and discarded.
- period_tick  in  1  one-cycle pulse, one cycle before each driver full-period reload.
- data_valid  in  1  data bit offered.
- data_ready  out  1  data bit consumed.
- data_bit  in  1  bit to modulate.
- drv_nrst  out  1  driver reset, active-low.
- drv_freq  out  FREQ_W  driver frequency.
- drv_div  out  DIV_W  driver pulse divisor.
- busy  out  1  state is ARM or RAMP.

Behaviour:
- Reset values: state OFF, drv_nrst=0, drv_freq=0, drv_div=DIV_START, tgt_freq=0, tgt_div=DIV_MIN, pend=0, cfg_ready=0, cfg_err=0, data_ready=0, busy=0. All outputs are registered except cfg_ready and data_ready, which are combinational from state.
- Handshakes:
  - A config transfer occurs when cfg_valid&&cfg_ready. Accepted cfg_div < DIV_MIN is stored as DIV_MIN.
  - A request with cfg_freq==0 is still consumed, but is discarded; cfg_err=1 the next cycle.
  - cfg_ready = (state==OFF) || (state==RUN && !pend).
- FSM states: OFF, ARM, RAMP, RUN.
- OFF:
  - drv_nrst=0.
  - Accepting a valid config latches tgt_freq, tgt_div and ramp.
  - With enable=1 and tgt_freq!=0, go to ARM.
- ARM:
  - drv_nrst=0, drv_freq=tgt_freq.
  - drv_div = ramp ? max(DIV_START, tgt_div) : tgt_div.
  - Hold counter runs HOLD_CYC cycles, then drv_nrst=1 and go to RAMP (if ramp and drv_div>tgt_div) else RUN.
- RAMP:
  - Dwell counter counts period_tick.
  - On the RAMP_DWELL-th tick, drv_div decrements by 1 in the cycle after that tick and the counter clears.
  - When drv_div reaches tgt_div, go to RUN.
  - No decrement below tgt_div.
- RUN: new config accepted.
  - cfg_freq != tgt_freq: latch and go to ARM, so the driver is reset mid-period.
  - Same frequency, different divisor: latch tgt_div and set pend. drv_div is updated on the next period_tick; pend clears.
  - If the new divisor is larger than drv_div, no ramp is applied. If smaller and ramp=1, go to RAMP from the current drv_div.
- Data modulation:
  - data_ready = (state==RUN) && period_tick && !pend.
  - On transfer, drv_div for the following period = data_bit ? tgt_div : max(DATA_DIV0, tgt_div).
  - On a period_tick with no transfer, drv_div = tgt_div.
- Simultaneous events:
  - enable=0 has priority over everything: next cycle state OFF, drv_nrst=0; target registers are retained.
  - Re-asserting enable with a valid stored target goes to ARM without a new config.
  - period_tick in the same cycle as a config accept: the divisor update waits for the next tick.
- rst mid-operation returns all state to reset values in one cycle.
- Widths: the dwell counter is clog2(RAMP_DWELL+1) bits; the hold counter saturates; the divisor never wraps.

Decomposition:
- Package swipt_pkg: state enum, DIV_MIN / DIV_START / DATA_DIV0 constants, and FREQ_W / DIV_W.
- Sub-module swipt_ramp: divisor ramp stepper (tick counter + decrement-to-target), instantiated once.

Test Plan:
- Reset and cold start:
  - Stimulus: rst 2 cycles, enable=1, config freq=50000, div=4, ramp=0.
  - Required: drv_nrst low exactly 4 cycles, then high; drv_freq=50000, drv_div=4; busy deasserts on entry to RUN.
- Soft start:
  - Stimulus: div=4, ramp=1, RAMP_DWELL=16.
  - Required: drv_div steps 15→14→…→4, one step per 16 period_ticks, 176 ticks total; cfg_ready low throughout.
- Divisor-only update:
  - Stimulus: in RUN, config freq=50000, div=6.
  - Required: drv_div stays 4 until the next period_tick, then 6; drv_nrst never drops.
- Frequency change:
  - Stimulus: in RUN, config freq=40000.
  - Required: drv_nrst drops next cycle for 4 cycles; drv_freq=40000.
- Data modulation:
  - Stimulus: bits 1,0,0,1 offered continuously, tgt_div=4.
  - Required: one bit per period_tick; drv_div sequence 4,8,8,4; drv_div returns to 4 when data_valid drops.
- Abort and error:
  - enable=0 during RAMP: OFF next cycle, drv_nrst=0.
  - Config with freq=0: consumed, cfg_err pulses once, targets unchanged.
